shift_reg_univ: RTL and testbench

//  Parametrised universal register: the WIDTH-bit generalisation of the enabled 4-bit D register.

---
 rtl/shift_reg_univ_pkg.sv | 22 ++
 rtl/shift_reg_univ_dff_en_bit.sv | 23 ++
 rtl/shift_reg_univ.sv | 117 +++++++++++
 tb/tb_shift_reg_univ.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_univ_pkg.sv
// Shared encodings for the universal shift register: operation modes and
// the multi-step engine state.
package shift_reg_univ_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // True for the four modes the multi-step engine can repeat.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_reg_univ_dff_en_bit.sv
// One storage bit: async reset and sync clear both force RST_VAL,
// otherwise d is captured when en is high.
module dff_en_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= RST_VAL;
        else if (clr)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: load, shift, rotate, sync clear, serial I/O
// and a multi-step shift engine driven by start/amt with busy/done handshake.
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic [CNT_W-1:0] amt,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       mode_reg, mode_next;
    logic             done_reg, done_next;

    logic [2:0]       op_mode;
    logic             q_en;
    logic [WIDTH-1:0] q_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mode_reg  <= MODE_HOLD;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            done_reg  <= done_next;
        end
    end

    // Priority: clr > SHIFT step > start > single op.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        done_next  = 1'b0;
        q_en       = 1'b0;
        op_mode    = mode;
        if (clr) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            mode_next  = MODE_HOLD;
        end else if (state_reg == ST_SHIFT) begin
            op_mode = mode_reg;
            if (en) begin
                q_en     = 1'b1;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
        end else if (start) begin
            if (is_shift_mode(mode) && (amt != '0)) begin
                state_next = ST_SHIFT;
                cnt_next   = amt;
                mode_next  = mode;
            end else begin
                done_next = 1'b1;
            end
        end else if (en) begin
            q_en = 1'b1;
        end
    end

    always_comb begin
        q_next = q;
        case (op_mode)
            MODE_LOAD: q_next = d;
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin};
            MODE_SHR:  q_next = {sin, q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            default:   q_next = q;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            dff_en_bit #(
                .RST_VAL(RESET_VAL[gi])
            ) u_bit (
                .clk  (clk),
                .reset(reset),
                .clr  (clr),
                .en   (q_en),
                .d    (q_next[gi]),
                .q    (q[gi])
            );
        end
    endgenerate

    logic [2:0] sout_mode;
    assign busy      = (state_reg == ST_SHIFT);
    assign done      = done_reg;
    assign sout_mode = busy ? mode_reg : mode;
    assign sout      = ((sout_mode == MODE_SHL) || (sout_mode == MODE_ROL)) ? q[WIDTH-1] : q[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed-vector bench for shift_reg_univ (WIDTH=8, RESET_VAL=0).
module tb_shift_reg_univ;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             clr;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [CNT_W-1:0] amt;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int check_cnt = 0;
    int pass_cnt  = 0;

    shift_reg_univ #(
        .WIDTH    (WIDTH),
        .RESET_VAL(8'h00),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clr  (clr),
        .mode (mode),
        .d    (d),
        .sin  (sin),
        .amt  (amt),
        .start(start),
        .q    (q),
        .sout (sout),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
            $display("ok   %-14s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end else begin
            $display("FAIL %-14s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        mode = 3'b001; d = val; en = 1'b1; start = 1'b0;
        step();
        mode = 3'b000;
    endtask

    int busy_cycles;
    int done_pulses;

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 3'b000;
        d = '0; sin = 1'b0; amt = '0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(q), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk); reset = 1'b0;
        #4;

        // 1. load then asynchronous reset mid-cycle
        load(8'hA5);
        check("t1_load", 32'(q), 32'hA5);
        #2 reset = 1'b1;
        #1;
        check("t1_async_q", 32'(q), 32'h00);
        check("t1_async_busy", 32'(busy), 32'd0);
        check("t1_async_done", 32'(done), 32'd0);
        @(negedge clk); reset = 1'b0;
        #4;

        // 2. enable gating, then SHL with serial in
        load(8'hA5);
        mode = 3'b001; d = 8'hFF; en = 1'b0;
        step();
        check("t2_en0_hold", 32'(q), 32'hA5);
        mode = 3'b010; sin = 1'b1; en = 1'b1;
        #1;
        check("t2_sout_shl", 32'(sout), 32'd1);
        step();
        check("t2_shl", 32'(q), 32'h4B);
        mode = 3'b000; sin = 1'b0;

        // 3. ROL by 3 with en held high
        load(8'h81);
        mode = 3'b100; amt = 4'd3; start = 1'b1; en = 1'b1;
        step();
        start = 1'b0; mode = 3'b000;
        check("t3_e0_q", 32'(q), 32'h81);
        check("t3_e0_busy", 32'(busy), 32'd1);
        step(); check("t3_s1", 32'(q), 32'h03);
        step(); check("t3_s2", 32'(q), 32'h06);
        check("t3_s2_busy", 32'(busy), 32'd1);
        step(); check("t3_s3", 32'(q), 32'h0C);
        check("t3_done", 32'(done), 32'd1);
        check("t3_busy_end", 32'(busy), 32'd0);
        step(); check("t3_done_pulse", 32'(done), 32'd0);

        // 3b. same op with one stalled cycle
        load(8'h81);
        mode = 3'b100; amt = 4'd3; start = 1'b1; en = 1'b1;
        busy_cycles = 0;
        step(); start = 1'b0; mode = 3'b000;
        if (busy) busy_cycles++;
        step(); if (busy) busy_cycles++;
        en = 1'b0;
        step(); if (busy) busy_cycles++;
        check("t3b_stall_q", 32'(q), 32'h03);
        en = 1'b1;
        step(); if (busy) busy_cycles++;
        step(); if (busy) busy_cycles++;
        check("t3b_q", 32'(q), 32'h0C);
        check("t3b_done", 32'(done), 32'd1);
        check("t3b_busy_cyc", 32'(busy_cycles), 32'd4);

        // 4. SHR by 10 (> WIDTH) fills entirely with sin
        load(8'hF0);
        mode = 3'b011; amt = 4'd10; sin = 1'b0; start = 1'b1; en = 1'b1;
        step(); start = 1'b0;
        mode = 3'b010;
        check("t4_sout_latch", 32'(sout), 32'd0);
        done_pulses = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            if (done) done_pulses++;
        end
        mode = 3'b000;
        check("t4_q", 32'(q), 32'h00);
        check("t4_done_cnt", 32'(done_pulses), 32'd1);

        // 5. clr aborts a ROR by 5 during step 2
        load(8'h3C);
        mode = 3'b101; amt = 4'd5; start = 1'b1; en = 1'b1;
        step(); start = 1'b0; mode = 3'b000;
        step();
        check("t5_s1", 32'(q), 32'h1E);
        clr = 1'b1;
        step(); clr = 1'b0;
        check("t5_clr_q", 32'(q), 32'h00);
        check("t5_clr_busy", 32'(busy), 32'd0);
        check("t5_clr_done", 32'(done), 32'd0);
        step();
        check("t5_no_done", 32'(done), 32'd0);

        // 6. amt=0 completes immediately; start while busy is dropped
        load(8'h5A);
        mode = 3'b010; amt = 4'd0; start = 1'b1; en = 1'b1;
        step(); start = 1'b0; mode = 3'b000;
        check("t6_amt0_q", 32'(q), 32'h5A);
        check("t6_amt0_done", 32'(done), 32'd1);
        check("t6_amt0_busy", 32'(busy), 32'd0);
        mode = 3'b010; amt = 4'd2; sin = 1'b0; start = 1'b1;
        step();
        mode = 3'b100; amt = 4'd1; start = 1'b1;
        done_pulses = 0;
        check("t6_busy_e0", 32'(busy), 32'd1);
        step(); start = 1'b0; mode = 3'b000;
        if (done) done_pulses++;
        check("t6_s1", 32'(q), 32'hB4);
        step();
        if (done) done_pulses++;
        check("t6_s2", 32'(q), 32'h68);
        check("t6_done_end", 32'(done), 32'd1);
        step();
        if (done) done_pulses++;
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_done_cnt", 32'(done_pulses), 32'd1);
        check("t6_final_q", 32'(q), 32'h68);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
